// File: rtl/hazard_detect_unit.sv
// Decode-stage hazard controller: load-use and branch-operand stalls, redirect
// flush for taken branches and jumps, stall-run tracking and saturating counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal flow, no stall in progress
// STALL | at least one stall cycle issued in the current run
// FLUSH | IF/ID holds the NOP behind a redirect; detection suppressed
module hazard_detect_unit #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             ID_uses_Rs,
    input  logic             ID_uses_Rt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_Jump,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_WriteReg,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             ID_Hazard_lwstall,
    output logic             ID_Hazard_Branch,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             hazard_error
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // run must hold MAX_STALL+1; one extra bit lets the increment be compared before saturating
    localparam int               RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W:0]   RUN_LIM = (RUN_W + 1)'(MAX_STALL);
    localparam logic [RUN_W:0]   RUN_SAT = (RUN_W + 1)'(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W:0]   run_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             err;

    logic m_ex;
    logic m_mem;
    logic lw_hz;
    logic br_hz;
    logic stall;
    logic redirect;

    // Operand match against the ID instruction's sources; $0 never matches
    assign m_ex  = (ID_EX_WriteReg != 5'd0) &&
                   ((ID_EX_WriteReg == IF_ID_RegisterRs && ID_uses_Rs) ||
                    (ID_EX_WriteReg == IF_ID_RegisterRt && ID_uses_Rt));
    assign m_mem = (EX_MEM_WriteReg != 5'd0) &&
                   ((EX_MEM_WriteReg == IF_ID_RegisterRs && ID_uses_Rs) ||
                    (EX_MEM_WriteReg == IF_ID_RegisterRt && ID_uses_Rt));

    assign lw_hz    = ID_EX_MemRead && m_ex;
    assign br_hz    = ID_Branch && ((ID_EX_RegWrite && m_ex) || (EX_MEM_MemRead && m_mem));
    // A branch still waiting on an operand must not resolve, so stall masks redirect
    assign stall    = (lw_hz || br_hz) && (state != S_FLUSH);
    assign redirect = !stall && (state != S_FLUSH) && (ID_Jump || (ID_Branch && ID_BranchTaken));

    assign run_inc  = (state == S_STALL) ? ({1'b0, run} + 1'b1) : (RUN_W + 1)'(1);

    // Outputs are forced to a neutral, advancing pipeline while reset is held
    assign PC_Write          = rst ? !stall : 1'b1;
    assign IF_ID_Write       = rst ? !stall : 1'b1;
    assign IF_Flush          = rst && redirect;
    assign ID_Hazard_lwstall = rst && stall;
    assign ID_Hazard_Branch  = rst && redirect;
    assign stall_count       = rst ? stall_cnt : '0;
    assign flush_count       = rst ? flush_cnt : '0;
    assign hazard_error      = rst && err;

    // Next-state selection; FLUSH always lasts exactly one cycle
    always_comb begin
        state_nxt = S_RUN;
        if (state != S_FLUSH) begin
            if (stall)
                state_nxt = S_STALL;
            else if (redirect)
                state_nxt = S_FLUSH;
        end
    end

    // State, stall-run tracking, sticky error and saturating counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RUN;
            run       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (stall) begin
                run <= (run_inc > RUN_SAT) ? RUN_SAT[RUN_W-1:0] : run_inc[RUN_W-1:0];
                if (run_inc > RUN_LIM)
                    err <= 1'b1;
            end else begin
                run <= '0;
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench for hazard_detect_unit: a behavioural model predicts the
// outputs of each cycle, the prediction is queued when stimulus is applied and
// compared against the DUT at the following falling edge.
module tb_hazard_detect_unit;

    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 2;
    localparam int M_RUN     = 0;
    localparam int M_STALL   = 1;
    localparam int M_FLUSH   = 2;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs, rt, ex_wr, mem_wr;
    logic urs, urt, br, taken, jmp, ex_mr, ex_rw, mem_mr;
    logic pc_write, if_id_write, if_flush, lwstall, br_bubble, hz_err;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct packed {
        logic             pc;
        logic             ifid;
        logic             fl;
        logic             lw;
        logic             br;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             err;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    int ms, mrun, msc, mfc;
    logic merr;

    always #5 clk = ~clk;

    hazard_detect_unit #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk               (clk),
        .rst               (rst),
        .IF_ID_RegisterRs  (rs),
        .IF_ID_RegisterRt  (rt),
        .ID_uses_Rs        (urs),
        .ID_uses_Rt        (urt),
        .ID_Branch         (br),
        .ID_BranchTaken    (taken),
        .ID_Jump           (jmp),
        .ID_EX_MemRead     (ex_mr),
        .ID_EX_RegWrite    (ex_rw),
        .ID_EX_WriteReg    (ex_wr),
        .EX_MEM_MemRead    (mem_mr),
        .EX_MEM_WriteReg   (mem_wr),
        .PC_Write          (pc_write),
        .IF_ID_Write       (if_id_write),
        .IF_Flush          (if_flush),
        .ID_Hazard_lwstall (lwstall),
        .ID_Hazard_Branch  (br_bubble),
        .stall_count       (stall_count),
        .flush_count       (flush_count),
        .hazard_error      (hz_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic m(input logic [4:0] r);
        return (r != 5'd0) && ((r == rs && urs) || (r == rt && urt));
    endfunction

    task automatic idle();
        rs = 0; rt = 0; urs = 0; urt = 0; br = 0; taken = 0; jmp = 0;
        ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 0; mem_wr = 0;
    endtask

    // One clock: predict, compare at negedge, then advance the model at posedge
    task automatic step();
        exp_t e, got;
        logic lw_hz, br_hz, stall, redir;
        lw_hz = ex_mr && m(ex_wr);
        br_hz = br && ((ex_rw && m(ex_wr)) || (mem_mr && m(mem_wr)));
        stall = (lw_hz || br_hz) && ms != M_FLUSH;
        redir = !stall && ms != M_FLUSH && (jmp || (br && taken));
        if (!rst) begin
            e = '0;
            e.pc = 1'b1;
            e.ifid = 1'b1;
        end else begin
            e.pc   = !stall;
            e.ifid = !stall;
            e.fl   = redir;
            e.lw   = stall;
            e.br   = redir;
            e.sc   = CNT_W'(msc);
            e.fc   = CNT_W'(mfc);
            e.err  = merr;
        end
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk("pc_write",    32'(pc_write),    32'(got.pc));
        chk("if_id_write", 32'(if_id_write), 32'(got.ifid));
        chk("if_flush",    32'(if_flush),    32'(got.fl));
        chk("lwstall",     32'(lwstall),     32'(got.lw));
        chk("br_bubble",   32'(br_bubble),   32'(got.br));
        chk("stall_count", 32'(stall_count), 32'(got.sc));
        chk("flush_count", 32'(flush_count), 32'(got.fc));
        chk("hazard_err",  32'(hz_err),      32'(got.err));
        @(posedge clk);
        if (!rst) begin
            ms = M_RUN; mrun = 0; msc = 0; mfc = 0; merr = 1'b0;
        end else begin
            if (stall) begin
                mrun = (ms == M_STALL) ? mrun + 1 : 1;
                if (mrun > MAX_STALL) merr = 1'b1;
                if (mrun > MAX_STALL + 1) mrun = MAX_STALL + 1;
                ms = M_STALL;
            end else begin
                mrun = 0;
                ms = redir ? M_FLUSH : M_RUN;
            end
            if (stall && msc != (1 << CNT_W) - 1) msc++;
            if (redir && mfc != (1 << CNT_W) - 1) mfc++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        ms = M_RUN; mrun = 0; msc = 0; mfc = 0; merr = 1'b0;
        idle();
        // Reset with a live hazard on the inputs: outputs must stay neutral
        ex_mr = 1; ex_wr = 5; rs = 5; urs = 1;
        do_reset();
        idle();

        // EX lw $5, ID add $6,$5,$7: one stall cycle
        ex_mr = 1; ex_rw = 1; ex_wr = 5; rs = 5; rt = 7; urs = 1; urt = 1;
        step();
        chk("lw_use_count", 32'(stall_count), 32'd1);
        idle();
        step();

        // EX lw $0, ID reads $0: no stall
        do_reset();
        ex_mr = 1; ex_rw = 1; ex_wr = 0; rs = 0; rt = 0; urs = 1; urt = 1;
        step();
        chk("zero_reg_count", 32'(stall_count), 32'd0);

        // EX add $8, ID beq $8,$9 taken: stall, redirect, flush (jump ignored in FLUSH)
        idle();
        ex_rw = 1; ex_wr = 8; rs = 8; rt = 9; urs = 1; urt = 1; br = 1; taken = 1;
        step();
        ex_rw = 0; ex_wr = 0;
        step();
        idle(); jmp = 1;
        step();
        idle();
        step();

        // EX lw $3 then MEM lw $3 under beq $3: two stalls, then redirect
        do_reset();
        rs = 3; urs = 1; br = 1; taken = 1; ex_mr = 1; ex_rw = 1; ex_wr = 3;
        step();
        ex_mr = 0; ex_rw = 0; ex_wr = 0; mem_mr = 1; mem_wr = 3;
        step();
        mem_mr = 0; mem_wr = 0;
        step();
        chk("br_lw_count", 32'(stall_count), 32'd2);
        chk("br_lw_err",   32'(hz_err),      32'd0);
        idle();
        step();

        // Three consecutive load-use stalls exceed the limit; error is sticky
        ex_mr = 1; ex_wr = 4; rt = 4; urt = 1;
        repeat (3) step();
        chk("run_err_set", 32'(hz_err), 32'd1);
        idle();
        repeat (3) step();
        do_reset();

        // Saturation of both counters, then reset abandons a stall
        ex_mr = 1; ex_wr = 6; rs = 6; urs = 1;
        repeat (20) step();
        chk("stall_sat", 32'(stall_count), 32'hf);
        idle(); jmp = 1;
        repeat (34) step();
        chk("flush_sat", 32'(flush_count), 32'hf);
        idle();
        ex_mr = 1; ex_wr = 6; rs = 6; urs = 1;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Random traffic over a small register space
        for (int i = 0; i < 300; i++) begin
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            ex_wr = 5'($urandom_range(0, 3)); mem_wr = 5'($urandom_range(0, 3));
            urs = 1'($urandom); urt = 1'($urandom); br = 1'($urandom);
            taken = 1'($urandom); jmp = ($urandom_range(0, 5) == 0);
            ex_mr = 1'($urandom); ex_rw = 1'($urandom); mem_mr = 1'($urandom);
            rst = ($urandom_range(0, 39) != 0);
            step();
        end
        rst = 1'b1;
        idle();
        step();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
